temp_entry_ctrl: RTL and testbench
==================================

TEMP_ENTRY_CTRL -- requirements
Module: temp_entry_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 2, number of BCD digits per temperature value (DW = 4*N_DIGITS).
REQ-002 SHALL have parameter N_LEVELS, default 4, number of alarm thresholds.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, idle clk cycles before a partial entry is discarded.
REQ-004 clk  in  1  single system clock, all state rising-edge.
REQ-005 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-006 rx_done_tick  in  1  one-cycle strobe: scan_code is valid.
REQ-007 scan_code  in  8  PS/2 set-2 byte from the keyboard receiver.
REQ-008 thr_bcd  in  N_LEVELS*DW  threshold i in bits [i*DW +: DW], BCD.
REQ-009 entry_bcd  out  DW  digits typed so far, right-aligned, for the display.
REQ-010 entry_active  out  1  high while an entry is in progress.
REQ-011 temp_bcd  out  DW  last committed temperature.
REQ-012 temp_valid  out  1  high once any value has been committed.
REQ-013 level  out  N_LEVELS  thermometer code: bit i = (temp_bcd >= threshold i).
REQ-014 err_tick  out  1  one-cycle pulse on rejected key, overflow or timeout.

Function
REQ-015 Key map: digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46; Enter = 5A (also E0 5A); Backspace = 66; Esc = 76; all other make codes are ignored without error.
REQ-016 Byte F0 SHALL set a break flag; the next byte is dropped and clears the flag; break bytes never act as keys.
REQ-017 Byte E0 SHALL set an extended flag for the next byte only; extended bytes other than 5A are ignored.
REQ-018 FSM states IDLE, ENTRY, COMMIT.
REQ-019 IDLE + digit -> ENTRY; count=1; entry_bcd=digit.
REQ-020 ENTRY + digit, count<N_DIGITS: entry_bcd shifts left 4 and appends the digit; count+1.
REQ-021 ENTRY + digit, count==N_DIGITS: digit dropped, err_tick, state held.
REQ-022 ENTRY + Backspace: entry_bcd shifts right 4; count-1; on count 0 -> IDLE.
REQ-023 ENTRY + Esc: entry cleared -> IDLE, no err_tick. IDLE + Esc: no effect.
REQ-024 ENTRY + Enter: -> COMMIT; temp_bcd<=entry_bcd and temp_valid<=1 on the same edge; entry cleared.
REQ-025 IDLE + Enter or Backspace: err_tick, no other change.
REQ-026 COMMIT lasts exactly one cycle; level is registered on that edge (temp_bcd visible at n+1, level at n+2 after an Enter at edge n); -> IDLE.
REQ-027 rx_done_tick during COMMIT: byte dropped, err_tick.
REQ-028 Timeout counter resets on every accepted byte in ENTRY; at TIMEOUT_CYC -> entry discarded, err_tick, IDLE; temp_bcd unchanged.
REQ-029 Comparison is unsigned on the BCD vectors; thresholds need not be ascending, and each level bit is independent.
REQ-030 level is recomputed only on COMMIT; thr_bcd changes take effect at the next commit.
REQ-031 entry_active = (state==ENTRY).

Reset
REQ-032 While reset=0: state=IDLE; count, flags, timeout counter = 0; entry_bcd=0, temp_bcd=0, temp_valid=0, level=0, err_tick=0.
REQ-033 Reset mid-entry or mid-COMMIT SHALL discard everything; no partial commit.

Structure
REQ-034 A shared package SHALL hold the scan-code constants, the FSM state encoding and the DW derivation.
REQ-035 One sub-module, ps2_key_decode, SHALL hold the break/extended flag logic and the key-class decode, with a registered key strobe, key class and digit value.
REQ-036 The timeout counter width SHALL be $clog2(TIMEOUT_CYC+1).

Verification
REQ-037 Keys 2,7,Enter with thresholds 25,27,30,37 -> temp_bcd=0x27, temp_valid=1, level=0b0011.
REQ-038 Keys 3,0,5 -> third digit rejected, err_tick once, entry_bcd=0x30; then Enter -> temp_bcd=0x30, level=0b0111.
REQ-039 Sequence 16 F0 16 1E F0 1E 5A -> temp_bcd=0x12; the break bytes produce no digits.
REQ-040 Keys 4, Backspace, Backspace -> IDLE, entry_bcd=0, one err_tick from the second Backspace (REQ-025).
REQ-041 Key 9 then no input for TIMEOUT_CYC (small value in sim) -> err_tick, IDLE, temp_bcd keeps the previous value.
REQ-042 reset=0 asserted asynchronously mid-entry -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/temp_entry_ctrl_pkg.sv
// Shared definitions for the temperature entry controller: scan codes,
// FSM and key-class encodings, and the BCD width derivation.
package temp_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'd0,
        KEY_ENTER = 2'd1,
        KEY_BKSP  = 2'd2,
        KEY_ESC   = 2'd3
    } key_cls_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    function automatic int bcd_width(input int n_digits);
        return 4 * n_digits;
    endfunction

    // Returns {hit, digit}; hit is 0 for anything that is not a digit key.
    function automatic logic [4:0] digit_lookup(input logic [7:0] sc);
        case (sc)
            8'h45:   return {1'b1, 4'd0};
            8'h16:   return {1'b1, 4'd1};
            8'h1E:   return {1'b1, 4'd2};
            8'h26:   return {1'b1, 4'd3};
            8'h25:   return {1'b1, 4'd4};
            8'h2E:   return {1'b1, 4'd5};
            8'h36:   return {1'b1, 4'd6};
            8'h3D:   return {1'b1, 4'd7};
            8'h3E:   return {1'b1, 4'd8};
            8'h46:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/temp_entry_ctrl_key_decode.sv
// PS/2 set-2 byte stream to key events: tracks break/extended prefixes and
// emits a registered one-cycle key strobe with its class and digit value.
module ps2_key_decode
    import temp_entry_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_code,
    output logic       key_stb,
    output key_cls_t   key_cls,
    output logic [3:0] key_digit
);

    logic       brk_reg, brk_next;
    logic       ext_reg, ext_next;
    logic       stb_reg, stb_next;
    key_cls_t   cls_reg, cls_next;
    logic [3:0] digit_reg, digit_next;
    logic [4:0] dig_hit;

    assign dig_hit = digit_lookup(scan_code);

    always_comb begin
        brk_next   = brk_reg;
        ext_next   = ext_reg;
        stb_next   = 1'b0;
        cls_next   = KEY_DIGIT;
        digit_next = 4'd0;
        if (rx_done_tick) begin
            if (brk_reg) begin
                // Byte following F0 is the released key: swallow it.
                brk_next = 1'b0;
                ext_next = 1'b0;
            end else if (scan_code == SC_BREAK) begin
                brk_next = 1'b1;
                ext_next = 1'b0;
            end else if (scan_code == SC_EXT) begin
                ext_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                if (ext_reg) begin
                    if (scan_code == SC_ENTER) begin
                        stb_next = 1'b1;
                        cls_next = KEY_ENTER;
                    end
                end else if (dig_hit[4]) begin
                    stb_next   = 1'b1;
                    cls_next   = KEY_DIGIT;
                    digit_next = dig_hit[3:0];
                end else if (scan_code == SC_ENTER) begin
                    stb_next = 1'b1;
                    cls_next = KEY_ENTER;
                end else if (scan_code == SC_BKSP) begin
                    stb_next = 1'b1;
                    cls_next = KEY_BKSP;
                end else if (scan_code == SC_ESC) begin
                    stb_next = 1'b1;
                    cls_next = KEY_ESC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_reg   <= 1'b0;
            ext_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            cls_reg   <= KEY_DIGIT;
            digit_reg <= 4'd0;
        end else begin
            brk_reg   <= brk_next;
            ext_reg   <= ext_next;
            stb_reg   <= stb_next;
            cls_reg   <= cls_next;
            digit_reg <= digit_next;
        end
    end

    assign key_stb   = stb_reg;
    assign key_cls   = cls_reg;
    assign key_digit = digit_reg;

endmodule

// File: rtl/temp_entry_ctrl.sv
// Keyboard temperature entry: collects BCD digits, commits on Enter and
// produces a thermometer-coded alarm level against per-level thresholds.
module temp_entry_ctrl
    import temp_entry_ctrl_pkg::*;
#(
    parameter int N_DIGITS    = 2,
    parameter int N_LEVELS    = 4,
    parameter int TIMEOUT_CYC = 50_000_000,
    localparam int DW         = bcd_width(N_DIGITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_done_tick,
    input  logic [7:0]             scan_code,
    input  logic [N_LEVELS*DW-1:0] thr_bcd,
    output logic [DW-1:0]          entry_bcd,
    output logic                   entry_active,
    output logic [DW-1:0]          temp_bcd,
    output logic                   temp_valid,
    output logic [N_LEVELS-1:0]    level,
    output logic                   err_tick
);

    localparam int CW = $clog2(N_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic       key_stb;
    key_cls_t   key_cls;
    logic [3:0] key_digit;

    ps2_key_decode u_decode (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .key_stb      (key_stb),
        .key_cls      (key_cls),
        .key_digit    (key_digit)
    );

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [DW-1:0]         entry_reg, entry_next;
    logic [DW-1:0]         temp_reg, temp_next;
    logic                  valid_reg, valid_next;
    logic [N_LEVELS-1:0]   level_reg, level_next;
    logic                  err_reg, err_next;
    logic [TW-1:0]         tmo_reg, tmo_next;
    logic [N_LEVELS-1:0]   thr_ge;

    // Each level bit is an independent unsigned compare against its threshold.
    generate
        for (genvar gi = 0; gi < N_LEVELS; gi++) begin : g_level
            assign thr_ge[gi] = (temp_reg >= thr_bcd[gi*DW +: DW]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        entry_next = entry_reg;
        temp_next  = temp_reg;
        valid_next = valid_reg;
        level_next = level_reg;
        err_next   = 1'b0;
        tmo_next   = tmo_reg;
        case (state_reg)
            ST_IDLE: begin
                tmo_next = '0;
                if (key_stb) begin
                    case (key_cls)
                        KEY_DIGIT: begin
                            state_next = ST_ENTRY;
                            cnt_next   = CW'(1);
                            entry_next = DW'(key_digit);
                        end
                        KEY_ENTER, KEY_BKSP: err_next = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_ENTRY: begin
                if (key_stb) begin
                    tmo_next = '0;
                    case (key_cls)
                        KEY_DIGIT: begin
                            if (cnt_reg < CW'(N_DIGITS)) begin
                                entry_next = (entry_reg << 4) | DW'(key_digit);
                                cnt_next   = cnt_reg + CW'(1);
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        KEY_BKSP: begin
                            entry_next = entry_reg >> 4;
                            cnt_next   = cnt_reg - CW'(1);
                            if (cnt_reg == CW'(1)) state_next = ST_IDLE;
                        end
                        KEY_ESC: begin
                            entry_next = '0;
                            cnt_next   = '0;
                            state_next = ST_IDLE;
                        end
                        default: begin
                            temp_next  = entry_reg;
                            valid_next = 1'b1;
                            entry_next = '0;
                            cnt_next   = '0;
                            state_next = ST_COMMIT;
                        end
                    endcase
                end else if (tmo_reg == TMO_LAST) begin
                    entry_next = '0;
                    cnt_next   = '0;
                    tmo_next   = '0;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            ST_COMMIT: begin
                level_next = thr_ge;
                err_next   = key_stb;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            entry_reg <= '0;
            temp_reg  <= '0;
            valid_reg <= 1'b0;
            level_reg <= '0;
            err_reg   <= 1'b0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            entry_reg <= entry_next;
            temp_reg  <= temp_next;
            valid_reg <= valid_next;
            level_reg <= level_next;
            err_reg   <= err_next;
            tmo_reg   <= tmo_next;
        end
    end

    assign entry_bcd    = entry_reg;
    assign entry_active = (state_reg == ST_ENTRY);
    assign temp_bcd     = temp_reg;
    assign temp_valid   = valid_reg;
    assign level        = level_reg;
    assign err_tick     = err_reg;

endmodule

// File: tb/tb_temp_entry_ctrl.sv
// Directed bench for temp_entry_ctrl: a key-level reference model is compared
// every cycle, plus hand-computed expectations at the end of each scenario.
module tb_temp_entry_ctrl;

    localparam int ND = 2;
    localparam int NL = 4;
    localparam int T  = 20;
    localparam int DW = 4 * ND;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               rx_done_tick = 1'b0;
    logic [7:0]         scan_code = 8'h00;
    logic [NL*DW-1:0]   thr_bcd = 32'h3730_2725;
    logic [DW-1:0]      entry_bcd;
    logic               entry_active;
    logic [DW-1:0]      temp_bcd;
    logic               temp_valid;
    logic [NL-1:0]      level;
    logic               err_tick;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    temp_entry_ctrl #(.N_DIGITS(ND), .N_LEVELS(NL), .TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .thr_bcd      (thr_bcd),
        .entry_bcd    (entry_bcd),
        .entry_active (entry_active),
        .temp_bcd     (temp_bcd),
        .temp_valid   (temp_valid),
        .level        (level),
        .err_tick     (err_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: key events are digits (0), Enter (1), Backspace (2), Esc (3).
    int m_phase, m_cnt, m_entry, m_temp, m_valid, m_level, m_err, m_idle;
    bit m_brk, m_ext, pk_v;
    int pk_k, pk_d;

    function automatic int digit_of(input logic [7:0] b);
        logic [7:0] codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    function automatic int thresh_level(input int t, input logic [NL*DW-1:0] thr);
        int lv = 0;
        for (int i = 0; i < NL; i++) begin
            int th = int'(thr[i*DW +: DW]);
            if (t >= th) lv += (1 << i);
        end
        return lv;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_cnt = 0; m_entry = 0; m_temp = 0; m_valid = 0;
            m_level = 0; m_err = 0; m_idle = 0; m_brk = 0; m_ext = 0; pk_v = 0;
            pk_k = 0; pk_d = 0;
        end else begin
            m_err = 0;
            if (m_phase == 2) begin
                m_level = thresh_level(m_temp, thr_bcd);
                m_phase = 0;
                if (pk_v) m_err = 1;
            end else if (m_phase == 0) begin
                m_idle = 0;
                if (pk_v && pk_k == 0) begin
                    m_phase = 1; m_cnt = 1; m_entry = pk_d;
                end else if (pk_v && (pk_k == 1 || pk_k == 2)) begin
                    m_err = 1;
                end
            end else if (pk_v) begin
                m_idle = 0;
                if (pk_k == 0) begin
                    if (m_cnt < ND) begin
                        m_entry = (m_entry * 16 + pk_d) % (1 << DW);
                        m_cnt++;
                    end else m_err = 1;
                end else if (pk_k == 2) begin
                    m_entry = m_entry / 16;
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 0;
                end else if (pk_k == 3) begin
                    m_entry = 0; m_cnt = 0; m_phase = 0;
                end else begin
                    m_temp = m_entry; m_valid = 1; m_entry = 0; m_cnt = 0; m_phase = 2;
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin
                    m_entry = 0; m_cnt = 0; m_phase = 0; m_err = 1; m_idle = 0;
                end
            end
            // Decode the byte sampled on this edge; it acts on the next one.
            pk_v = 0;
            if (rx_done_tick) begin
                if (m_brk) begin
                    m_brk = 0; m_ext = 0;
                end else if (scan_code == 8'hF0) begin
                    m_brk = 1; m_ext = 0;
                end else if (scan_code == 8'hE0) begin
                    m_ext = 1;
                end else begin
                    if (m_ext) begin
                        if (scan_code == 8'h5A) begin pk_v = 1; pk_k = 1; end
                    end else if (digit_of(scan_code) >= 0) begin
                        pk_v = 1; pk_k = 0; pk_d = digit_of(scan_code);
                    end else if (scan_code == 8'h5A) begin pk_v = 1; pk_k = 1; end
                    else if (scan_code == 8'h66) begin pk_v = 1; pk_k = 2; end
                    else if (scan_code == 8'h76) begin pk_v = 1; pk_k = 3; end
                    m_ext = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("entry_bcd", int'(entry_bcd), m_entry);
        check("entry_active", int'(entry_active), int'(m_phase == 1));
        check("temp_bcd", int'(temp_bcd), m_temp);
        check("temp_valid", int'(temp_valid), m_valid);
        check("level", int'(level), m_level);
        check("err_tick", int'(err_tick), m_err);
        if (err_tick) err_seen++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        scan_code    = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        check("rst_temp_valid", int'(temp_valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_entry", int'(entry_bcd), 0);
        reset = 1'b1;
        idle(2);

        // 2, 7, Enter -> 27 against thresholds 25,27,30,37
        send(8'h1E); send(8'h3D); send(8'h5A); idle(3);
        $display("txn keys 2,7,Enter: temp=%h level=%b", temp_bcd, level);
        check("t1_temp", int'(temp_bcd), 'h27);
        check("t1_valid", int'(temp_valid), 1);
        check("t1_level", int'(level), 'b0011);

        // 3, 0, 5 -> third digit rejected
        err_seen = 0;
        send(8'h26); send(8'h45); send(8'h2E); idle(2);
        $display("txn keys 3,0,5: entry=%h errs=%0d", entry_bcd, err_seen);
        check("t2_errs", err_seen, 1);
        check("t2_entry", int'(entry_bcd), 'h30);
        send(8'h5A); idle(3);
        $display("txn Enter: temp=%h level=%b", temp_bcd, level);
        check("t2_temp", int'(temp_bcd), 'h30);
        check("t2_level", int'(level), 'b0111);

        // make/break pairs
        send(8'h16); send(8'hF0); send(8'h16); send(8'h1E);
        send(8'hF0); send(8'h1E); send(8'h5A); idle(3);
        $display("txn 16 F0 16 1E F0 1E 5A: temp=%h level=%b", temp_bcd, level);
        check("t3_temp", int'(temp_bcd), 'h12);
        check("t3_level", int'(level), 'b0000);

        // 4, Backspace, Backspace
        err_seen = 0;
        send(8'h25); send(8'h66); send(8'h66); idle(2);
        $display("txn 4,BS,BS: active=%b entry=%h errs=%0d", entry_active, entry_bcd, err_seen);
        check("t4_active", int'(entry_active), 0);
        check("t4_entry", int'(entry_bcd), 0);
        check("t4_errs", err_seen, 1);

        // 9 then silence past the timeout
        err_seen = 0;
        send(8'h46); idle(T + 5);
        $display("txn 9,timeout: active=%b temp=%h errs=%0d", entry_active, temp_bcd, err_seen);
        check("t5_active", int'(entry_active), 0);
        check("t5_temp", int'(temp_bcd), 'h12);
        check("t5_errs", err_seen, 1);

        // extended prefix: E0 16 ignored, 2, E0 5A commits; then Esc paths
        err_seen = 0;
        send(8'hE0); send(8'h16); send(8'h1E); send(8'hE0); send(8'h5A); idle(3);
        send(8'h36); send(8'h76); send(8'h76); idle(2);
        $display("txn E0 16, 2, E0 5A, 6, Esc, Esc: temp=%h errs=%0d", temp_bcd, err_seen);
        check("t6_temp", int'(temp_bcd), 'h02);
        check("t6_errs", err_seen, 0);
        check("t6_active", int'(entry_active), 0);

        // key landing during COMMIT is dropped with an error
        err_seen = 0;
        send(8'h16);
        @(negedge clk); rx_done_tick = 1'b1; scan_code = 8'h5A;
        @(negedge clk); scan_code = 8'h3E;
        @(negedge clk); rx_done_tick = 1'b0;
        idle(3);
        $display("txn 1,Enter,8(commit): temp=%h active=%b errs=%0d", temp_bcd, entry_active, err_seen);
        check("t7_temp", int'(temp_bcd), 'h01);
        check("t7_active", int'(entry_active), 0);
        check("t7_errs", err_seen, 1);

        // threshold change only takes effect at the next commit
        thr_bcd = 32'h0000_0109;
        idle(3);
        check("t8_level_hold", int'(level), 0);
        send(8'h2E); send(8'h5A); idle(3);
        $display("txn 5,Enter new thr: temp=%h level=%b", temp_bcd, level);
        check("t8_level", int'(level), 'b1110);

        // asynchronous reset mid-entry
        send(8'h25);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        $display("txn async reset: entry=%h temp=%h valid=%b level=%b",
                 entry_bcd, temp_bcd, temp_valid, level);
        check("t9_entry", int'(entry_bcd), 0);
        check("t9_active", int'(entry_active), 0);
        check("t9_temp", int'(temp_bcd), 0);
        check("t9_valid", int'(temp_valid), 0);
        check("t9_level", int'(level), 0);
        check("t9_err", int'(err_tick), 0);
        idle(2);
        reset = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
